fa_share_arbiter: RTL

- Shares one WIDTH-bit integer adder among NREQ requesters in the fp32 adder-tree datapath.
- The adder is combinational, carry-in 0, sum modulo 2^WIDTH.
- A round-robin arbiter picks one requester per cycle. Its operands go through the shared adder, and the result is captured in a single output register with the requester tag.
- Valid/ready handshakes apply on both sides; a running count of completed additions is kept for debug.

---
 rtl/fa_share_arbiter_if.sv | 41 ++++
 rtl/fa_share_arbiter.sv | 105 ++++++++++
 2 files changed

// File: rtl/fa_share_arbiter_if.sv
// Handshake bundle between NREQ adder requesters, the shared-adder arbiter and its consumer.
// out_cout exists only when FA_ARB_CARRY_OUT_EN is defined.
interface fa_share_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int TAGW  = 2,
  parameter int CNTW  = 16
) ();
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_sum;
  logic [TAGW-1:0]       out_tag;
  logic                  out_ready;
  logic [CNTW-1:0]       op_count;
`ifdef FA_ARB_CARRY_OUT_EN
  logic                  out_cout;

  modport master (
    output req_valid, req_a, req_b, out_ready,
    input  req_ready, out_valid, out_sum, out_tag, op_count, out_cout
  );

  modport slave (
    input  req_valid, req_a, req_b, out_ready,
    output req_ready, out_valid, out_sum, out_tag, op_count, out_cout
  );
`else
  modport master (
    output req_valid, req_a, req_b, out_ready,
    input  req_ready, out_valid, out_sum, out_tag, op_count
  );

  modport slave (
    input  req_valid, req_a, req_b, out_ready,
    output req_ready, out_valid, out_sum, out_tag, op_count
  );
`endif
endinterface

// File: rtl/fa_share_arbiter.sv
// Round-robin sharing of one WIDTH-bit combinational adder among NREQ requesters, one result register.
// Optional macro FA_ARB_CARRY_OUT_EN adds a registered carry-out on out_cout.
module fa_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int TAGW  = 2,
  parameter int CNTW  = 16
) (
  input logic               clk,
  input logic               rst_n,
  fa_share_arbiter_if.slave bus
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state;
  logic [TAGW-1:0]  rr_ptr;
  logic [TAGW-1:0]  grant;
  logic [TAGW-1:0]  tag_q;
  logic [TAGW:0]    idx;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] add_sum;
  logic [WIDTH-1:0] sum_q;
  logic [CNTW-1:0]  count_q;
  logic [NREQ-1:0]  ready;
  logic             grant_any;
  logic             can_accept;
  logic             accept;
  logic             drain;

  // Walk the requesters starting at rr_ptr with wrap; the first valid one wins.
  always_comb begin
    grant_any = 1'b0;
    grant     = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, rr_ptr} + (TAGW+1)'(k);
      if (idx >= (TAGW+1)'(NREQ)) idx = idx - (TAGW+1)'(NREQ);
      if (!grant_any && |(bus.req_valid & (NREQ'(1) << idx))) begin
        grant_any = 1'b1;
        grant     = idx[TAGW-1:0];
      end
    end
  end

  assign can_accept = (state == EMPTY) || bus.out_ready;
  assign drain      = (state == FULL) && bus.out_ready;

  always_comb begin
    ready = '0;
    op_a  = '0;
    op_b  = '0;
    for (int k = 0; k < NREQ; k++) begin
      ready[k] = rst_n && can_accept && grant_any && (grant == TAGW'(k));
      if (grant == TAGW'(k)) begin
        op_a = bus.req_a[k*WIDTH +: WIDTH];
        op_b = bus.req_b[k*WIDTH +: WIDTH];
      end
    end
  end

  assign accept = |ready;

`ifdef FA_ARB_CARRY_OUT_EN
  logic add_cout;
  logic cout_q;
  assign {add_cout, add_sum} = {1'b0, op_a} + {1'b0, op_b};
  assign bus.out_cout = cout_q;
`else
  assign add_sum = op_a + op_b;
`endif

  // A drain and a refill in the same cycle leave the register FULL.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= EMPTY;
      sum_q   <= '0;
      tag_q   <= '0;
      count_q <= '0;
      rr_ptr  <= '0;
`ifdef FA_ARB_CARRY_OUT_EN
      cout_q  <= 1'b0;
`endif
    end else begin
      if (drain) count_q <= count_q + 1'b1;
      if (accept) begin
        state  <= FULL;
        sum_q  <= add_sum;
        tag_q  <= grant;
        rr_ptr <= (grant == TAGW'(NREQ-1)) ? '0 : grant + 1'b1;
`ifdef FA_ARB_CARRY_OUT_EN
        cout_q <= add_cout;
`endif
      end else if (drain) begin
        state <= EMPTY;
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.out_valid = (state == FULL);
  assign bus.out_sum   = sum_q;
  assign bus.out_tag   = tag_q;
  assign bus.op_count  = count_q;
endmodule
